// File: rtl/trig_frame_rx.sv
// Trigger-framed serial receiver: a trig pulse starts a frame of WIDTH data bits
// (MSB first) plus an optional even-parity bit, delivered as a parallel word.
module trig_frame_rx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             data_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             perr_o,
    output logic             abort_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             par_q;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             perr_q;
    logic             abort_q;
    logic             busy_q;

    logic [WIDTH-1:0] shreg_d;
    logic             par_d;
    logic             last_bit;

    // Shift written as a shift-and-or so WIDTH=1 needs no zero-width slice.
    always_comb begin
        shreg_d  = (shreg_q << 1) | WIDTH'(data_i);
        par_d    = par_q ^ data_i;
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            word_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q <= SHIFT;
                        shreg_q <= '0;
                        cnt_q   <= '0;
                        par_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (last_bit && !PARITY_EN) begin
                        // Completion takes priority over a coincident trig.
                        word_q  <= shreg_d;
                        perr_q  <= 1'b0;
                        valid_q <= 1'b1;
                        shreg_q <= '0;
                        cnt_q   <= '0;
                        par_q   <= 1'b0;
                        state_q <= trig ? SHIFT : IDLE;
                        busy_q  <= trig;
                    end else if (trig) begin
                        abort_q <= 1'b1;
                        shreg_q <= '0;
                        cnt_q   <= '0;
                        par_q   <= 1'b0;
                    end else begin
                        shreg_q <= shreg_d;
                        par_q   <= par_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (last_bit) begin
                            state_q <= PARITY;
                        end
                    end
                end

                PARITY: begin
                    word_q  <= shreg_q;
                    perr_q  <= par_d;
                    valid_q <= 1'b1;
                    shreg_q <= '0;
                    cnt_q   <= '0;
                    par_q   <= 1'b0;
                    state_q <= trig ? SHIFT : IDLE;
                    busy_q  <= trig;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign word_o  = word_q;
    assign valid_o = valid_q;
    assign perr_o  = perr_q;
    assign abort_o = abort_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_trig_frame_rx.sv
// Directed bench for trig_frame_rx: an 8-bit parity instance and a 4-bit
// no-parity instance, driven one clock step at a time.
module tb_trig_frame_rx;

    logic       clk;
    logic       rst_n;
    logic       trig8, data8, trig4, data4;
    logic [7:0] word8;
    logic       valid8, perr8, abort8, busy8;
    logic [3:0] word4;
    logic       valid4, perr4, abort4, busy4;

    int checks = 0;
    int errors = 0;
    int valid_cnt, abort_cnt, busy_cnt;

    trig_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .trig(trig8), .data_i(data8),
        .word_o(word8), .valid_o(valid8), .perr_o(perr8),
        .abort_o(abort8), .busy_o(busy8)
    );

    trig_frame_rx #(.WIDTH(4), .PARITY_EN(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .trig(trig4), .data_i(data4),
        .word_o(word4), .valid_o(valid4), .perr_o(perr4),
        .abort_o(abort4), .busy_o(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 ns later.
    task automatic step(input logic t8, input logic d8, input logic t4, input logic d4);
        trig8 = t8; data8 = d8; trig4 = t4; data4 = d4;
        @(posedge clk);
        #1;
        valid_cnt += int'(valid8);
        abort_cnt += int'(abort8);
        busy_cnt  += int'(busy8);
    endtask

    task automatic step8(input logic t, input logic d);
        step(t, d, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        valid_cnt = 0; abort_cnt = 0; busy_cnt = 0;
    endtask

    task automatic send_bits8(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) step8(1'b0, w[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        trig8 = 1'b0; data8 = 1'b0; trig4 = 1'b0; data4 = 1'b0;
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check("rst_word",  32'(word8),  32'h0);
        check("rst_valid", 32'(valid8), 32'h0);
        check("rst_busy",  32'(busy8),  32'h0);
        check("rst_abort", 32'(abort8), 32'h0);
        rst_n = 1'b1;

        // Basic frame A5, parity 0
        clear_counts();
        step8(1'b1, 1'b1);
        check("basic_busy_e0", 32'(busy8), 32'h1);
        send_bits8(8'hA5);
        check("basic_no_early_valid", 32'(valid_cnt), 32'h0);
        step8(1'b0, 1'b0);
        check("basic_valid", 32'(valid8), 32'h1);
        check("basic_word",  32'(word8),  32'hA5);
        check("basic_perr",  32'(perr8),  32'h0);
        check("basic_busy_done", 32'(busy8), 32'h0);
        step8(1'b0, 1'b1);
        check("basic_valid_once", 32'(valid_cnt), 32'h1);
        check("basic_busy_cycles", 32'(busy_cnt), 32'd9);
        check("basic_word_hold", 32'(word8), 32'hA5);

        // Parity error: A5 with parity 1
        clear_counts();
        step8(1'b1, 1'b0);
        send_bits8(8'hA5);
        step8(1'b0, 1'b1);
        check("perr_word", 32'(word8), 32'hA5);
        check("perr_flag", 32'(perr8), 32'h1);
        step8(1'b0, 1'b0);
        check("perr_valid_once", 32'(valid_cnt), 32'h1);
        check("perr_hold", 32'(perr8), 32'h1);

        // Abort and restart with 3C
        clear_counts();
        step8(1'b1, 1'b0);
        step8(1'b0, 1'b1);
        step8(1'b0, 1'b1);
        step8(1'b0, 1'b1);
        step8(1'b1, 1'b1);
        check("abort_pulse", 32'(abort8), 32'h1);
        check("abort_busy", 32'(busy8), 32'h1);
        check("abort_word_kept", 32'(word8), 32'hA5);
        send_bits8(8'h3C);
        step8(1'b0, 1'b0);
        check("abort_word", 32'(word8), 32'h3C);
        check("abort_perr", 32'(perr8), 32'h0);
        step8(1'b0, 1'b0);
        check("abort_count", 32'(abort_cnt), 32'h1);
        check("abort_valid_count", 32'(valid_cnt), 32'h1);

        // Back-to-back FF then 01, second trig on first parity edge
        clear_counts();
        step8(1'b1, 1'b0);
        send_bits8(8'hFF);
        step8(1'b1, 1'b0);
        check("b2b_valid1", 32'(valid8), 32'h1);
        check("b2b_word1",  32'(word8),  32'hFF);
        check("b2b_perr1",  32'(perr8),  32'h0);
        check("b2b_busy",   32'(busy8),  32'h1);
        send_bits8(8'h01);
        step8(1'b0, 1'b1);
        check("b2b_word2", 32'(word8), 32'h01);
        check("b2b_perr2", 32'(perr8), 32'h0);
        step8(1'b0, 1'b0);
        check("b2b_valid_count", 32'(valid_cnt), 32'h2);
        check("b2b_no_abort", 32'(abort_cnt), 32'h0);

        // Asynchronous reset mid-frame, then 5A
        step8(1'b1, 1'b0);
        step8(1'b0, 1'b0);
        step8(1'b0, 1'b1);
        step8(1'b0, 1'b0);
        step8(1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy8), 32'h0);
        check("arst_word", 32'(word8), 32'h0);
        check("arst_valid", 32'(valid8), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_counts();
        step8(1'b0, 1'b1);
        step8(1'b1, 1'b0);
        send_bits8(8'h5A);
        step8(1'b0, 1'b0);
        check("arst_rx_word", 32'(word8), 32'h5A);
        check("arst_rx_perr", 32'(perr8), 32'h0);
        step8(1'b0, 1'b0);
        check("arst_valid_count", 32'(valid_cnt), 32'h1);

        // No-parity 4-bit instance: 1,1,0,1 then 0,0,0,1
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("np_busy", 32'(busy4), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("np_no_early_valid", 32'(valid4), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("np_valid", 32'(valid4), 32'h1);
        check("np_word",  32'(word4),  32'hD);
        check("np_perr",  32'(perr4),  32'h0);
        check("np_busy_done", 32'(busy4), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("np_valid_pulse", 32'(valid4), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("np_word_odd", 32'(word4), 32'h1);
        check("np_perr_held", 32'(perr4), 32'h0);
        check("np_no_abort", 32'(abort4), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
